rm_ihpsg13_1p_256x48_bist_ctrl: RTL and testbench
=================================================

RM_IHPSG13_1P_256X48_BIST_CTRL -- requirements
Module: RM_IHPSG13_1P_256x48_bist_ctrl

Interface
REQ-001 Parameter: P_DATA_WIDTH, 48, SRAM word width.
REQ-002 Parameter: P_ADDR_WIDTH, 8, SRAM address width (depth 2**P_ADDR_WIDTH = 256).
REQ-003 A_CLK  input  1  single clock; shall also drive the SRAM A_BIST_CLK.
REQ-004 A_RST  input  1  reset; synchronous, active-high.
REQ-005 A_START  input  1  one-cycle request to launch a March C- run.
REQ-006 A_BUSY  output  1  high while a run is in progress.
REQ-007 A_DONE  output  1  run complete; held until the next accepted start or reset.
REQ-008 A_FAIL  output  1  sticky: at least one compare mismatch in the current or last run.
REQ-009 A_FAIL_ADDR  output  P_ADDR_WIDTH  address of the first mismatch.
REQ-010 A_FAIL_ELEM  output  3  March element index (0-5) of the first mismatch.
REQ-011 A_FAIL_BITS  output  P_DATA_WIDTH  XOR syndrome (expected ^ A_DOUT) of the first mismatch.
REQ-012 A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN  output  1 each  SRAM BIST port controls.
REQ-013 A_BIST_ADDR  output  P_ADDR_WIDTH; A_BIST_DIN, A_BIST_BM  output  P_DATA_WIDTH  SRAM BIST address, data and bit mask.
REQ-014 A_DOUT  input  P_DATA_WIDTH  SRAM read data.

Function
REQ-015 The FSM shall have four states: IDLE, RUN, FLUSH, DONE.
- IDLE/DONE -> RUN on A_START.
- RUN -> FLUSH after the last op.
- FLUSH -> DONE after 1 cycle.
- A_START in RUN/FLUSH shall be ignored.
REQ-016 The algorithm shall be March C-, executed in element order:
- E0 up(w0)
- E1 up(r0,w1)
- E2 up(r1,w0)
- E3 down(r0,w1)
- E4 down(r1,w0)
- E5 up(r0)
REQ-017 "0" shall mean all-zero data and "1" all-ones data.
REQ-018 One SRAM op shall be issued per cycle in RUN. Within a two-op element, both ops shall hit the same address before it advances. Total RUN length shall be 2560 cycles.
REQ-019 Address order:
- up elements count 0x00 -> 0xFF.
- down elements count 0xFF -> 0x00.
- The element shall advance when the last address wraps.
REQ-020 Port drive during RUN:
- A_BIST_EN = A_BIST_MEN = 1.
- Exactly one of A_BIST_WEN/A_BIST_REN = 1.
- A_BIST_BM = all ones.
- A_BIST_DIN = the element's write background during writes, 0 otherwise.
REQ-021 In IDLE, FLUSH and DONE, all A_BIST_* outputs shall be 0, with A_BIST_EN = 0.
REQ-022 Read compare shall be pipelined:
- A read issued in the cycle before edge N shall be compared against A_DOUT at edge N+1.
- Expected data, address and element shall be carried in a one-stage pipeline register.
REQ-023 FLUSH shall exist solely to compare the final E5 read.
REQ-024 On the first mismatch of a run:
- A_FAIL shall set.
- A_FAIL_ADDR, A_FAIL_ELEM and A_FAIL_BITS shall be captured.
- Later mismatches shall not overwrite the captured values.
- The run shall continue to completion.
REQ-025 Timing from the edge that samples A_START:
- Op 0 (E0 w0, address 0) shall be driven immediately after that edge.
- A_BUSY shall rise immediately after that edge.
- A_DONE shall rise, and A_BUSY fall, 2561 edges later.
REQ-026 An accepted start shall clear A_DONE, A_FAIL, A_FAIL_ADDR, A_FAIL_ELEM and A_FAIL_BITS on the same edge.
REQ-027 A mismatch and the start of a new run cannot coincide. Compares shall occur only in RUN and FLUSH.

Reset
REQ-028 A_RST shall be sampled on the A_CLK edge, with A_RST priority over A_START.
REQ-029 Reset shall force:
- state = IDLE
- A_BUSY = A_DONE = A_FAIL = 0
- A_FAIL_ADDR = 0, A_FAIL_ELEM = 0, A_FAIL_BITS = 0
- all A_BIST_* = 0
- address and element counters = 0
- the compare pipeline invalid
REQ-030 Reset mid-run shall abort the run immediately. No further SRAM op or compare shall occur, and A_DONE shall not assert.

Verification
REQ-031 Fault-free run with the behavioural SRAM model: pulse A_START -> A_DONE = 1 exactly 2561 cycles later, A_FAIL = 0, 1280 write ops and 1280 read ops counted on the BIST port.
REQ-032 Stuck-at-1 on A_DOUT[5] when the address read is 0x10 -> A_FAIL = 1, A_FAIL_ADDR = 0x10, A_FAIL_ELEM = 1, A_FAIL_BITS = 0x000000000020, A_DONE still at cycle 2561.
REQ-033 Address order: A_BIST_ADDR on the first E3 op = 0xFF and on the last E4 op = 0x00. Element transitions occur at op indices 256, 768, 1280, 1792 and 2304.
REQ-034 A_RST asserted at cycle 1000 of a run -> next cycle A_BUSY = 0, A_BIST_EN = 0, all outputs at reset values. A subsequent A_START -> complete run with A_DONE at cycle 2561.
REQ-035 A_START re-pulsed at cycles 5 and 2560 -> both ignored, A_DONE timing unchanged. A_START after A_DONE with the prior A_FAIL = 1 -> A_DONE and A_FAIL cleared on the same edge and the run restarts.

Source files
------------

// File: rtl/rm_ihpsg13_1p_256x48_bist_ctrl.sv
// March C- BIST controller for the 256x48 single-port SRAM BIST port.
// Drives one SRAM op per cycle and compares reads through a one-stage pipeline.
module rm_ihpsg13_1p_256x48_bist_ctrl #(
    parameter int P_DATA_WIDTH = 48,
    parameter int P_ADDR_WIDTH = 8
) (
    input  logic                    A_CLK,
    input  logic                    A_RST,
    input  logic                    A_START,
    output logic                    A_BUSY,
    output logic                    A_DONE,
    output logic                    A_FAIL,
    output logic [P_ADDR_WIDTH-1:0] A_FAIL_ADDR,
    output logic [2:0]              A_FAIL_ELEM,
    output logic [P_DATA_WIDTH-1:0] A_FAIL_BITS,
    output logic                    A_BIST_EN,
    output logic                    A_BIST_MEN,
    output logic                    A_BIST_WEN,
    output logic                    A_BIST_REN,
    output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
    output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
    output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
    input  logic [P_DATA_WIDTH-1:0] A_DOUT
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [P_ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [2:0]              LAST_ELEM = 3'd5;

    state_t                    state;
    logic [2:0]                elem;
    logic [P_ADDR_WIDTH-1:0]   addr;
    logic                      phase;

    logic                      cmp_valid;
    logic [P_DATA_WIDTH-1:0]   cmp_exp;
    logic [P_ADDR_WIDTH-1:0]   cmp_addr;
    logic [2:0]                cmp_elem;

    logic                      issue;
    logic                      last_op;
    logic [2:0]                nxt_elem;
    logic [P_ADDR_WIDTH-1:0]   nxt_addr;
    logic                      nxt_phase;
    logic [2:0]                op_elem;
    logic [P_ADDR_WIDTH-1:0]   op_addr;
    logic                      op_phase;
    logic                      op_read;
    logic                      op_ones;

    // E3/E4 walk the address space downwards, all others upwards.
    function automatic logic elem_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic elem_two_op(input logic [2:0] e);
        return (e >= 3'd1) && (e <= 3'd4);
    endfunction

    // Data background expected by the read of an element.
    function automatic logic elem_read_ones(input logic [2:0] e);
        return (e == 3'd2) || (e == 3'd4);
    endfunction

    // Data background written by an element.
    function automatic logic elem_write_ones(input logic [2:0] e);
        return (e == 3'd1) || (e == 3'd3);
    endfunction

    function automatic logic op_is_read(input logic [2:0] e, input logic p);
        return (e == LAST_ELEM) || (elem_two_op(e) && !p);
    endfunction

    // Successor of the op currently on the port.
    always_comb begin
        nxt_elem  = elem;
        nxt_addr  = addr;
        nxt_phase = 1'b0;
        last_op   = 1'b0;
        if (elem_two_op(elem) && !phase) begin
            nxt_phase = 1'b1;
        end else if (addr == (elem_down(elem) ? '0 : '1)) begin
            if (elem == LAST_ELEM) begin
                last_op = 1'b1;
            end else begin
                nxt_elem = elem + 3'd1;
                nxt_addr = elem_down(elem + 3'd1) ? '1 : '0;
            end
        end else begin
            nxt_addr = elem_down(elem) ? (addr - ADDR_ONE) : (addr + ADDR_ONE);
        end
    end

    // Op to be driven in the coming cycle: op 0 on an accepted start, else the successor.
    always_comb begin
        issue    = 1'b0;
        op_elem  = nxt_elem;
        op_addr  = nxt_addr;
        op_phase = nxt_phase;
        case (state)
            IDLE, DONE: begin
                if (A_START) begin
                    issue    = 1'b1;
                    op_elem  = '0;
                    op_addr  = '0;
                    op_phase = 1'b0;
                end
            end
            RUN:     issue = !last_op;
            default: issue = 1'b0;
        endcase
        op_read = op_is_read(op_elem, op_phase);
        op_ones = !op_read && elem_write_ones(op_elem);
    end

    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            state       <= IDLE;
            elem        <= '0;
            addr        <= '0;
            phase       <= 1'b0;
            cmp_valid   <= 1'b0;
            cmp_exp     <= '0;
            cmp_addr    <= '0;
            cmp_elem    <= '0;
            A_BUSY      <= 1'b0;
            A_DONE      <= 1'b0;
            A_FAIL      <= 1'b0;
            A_FAIL_ADDR <= '0;
            A_FAIL_ELEM <= '0;
            A_FAIL_BITS <= '0;
            A_BIST_EN   <= 1'b0;
            A_BIST_MEN  <= 1'b0;
            A_BIST_WEN  <= 1'b0;
            A_BIST_REN  <= 1'b0;
            A_BIST_ADDR <= '0;
            A_BIST_DIN  <= '0;
            A_BIST_BM   <= '0;
        end else begin
            // Read data for the op sampled at the previous edge is valid now.
            if (cmp_valid && (A_DOUT != cmp_exp) && !A_FAIL) begin
                A_FAIL      <= 1'b1;
                A_FAIL_ADDR <= cmp_addr;
                A_FAIL_ELEM <= cmp_elem;
                A_FAIL_BITS <= cmp_exp ^ A_DOUT;
            end
            cmp_valid <= (state == RUN) && A_BIST_REN;
            cmp_exp   <= {P_DATA_WIDTH{elem_read_ones(elem)}};
            cmp_addr  <= addr;
            cmp_elem  <= elem;

            case (state)
                IDLE, DONE: begin
                    if (A_START) begin
                        state       <= RUN;
                        A_BUSY      <= 1'b1;
                        A_DONE      <= 1'b0;
                        A_FAIL      <= 1'b0;
                        A_FAIL_ADDR <= '0;
                        A_FAIL_ELEM <= '0;
                        A_FAIL_BITS <= '0;
                    end
                end
                RUN: begin
                    if (last_op) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    state  <= DONE;
                    A_BUSY <= 1'b0;
                    A_DONE <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            if (issue) begin
                elem        <= op_elem;
                addr        <= op_addr;
                phase       <= op_phase;
                A_BIST_EN   <= 1'b1;
                A_BIST_MEN  <= 1'b1;
                A_BIST_WEN  <= !op_read;
                A_BIST_REN  <= op_read;
                A_BIST_ADDR <= op_addr;
                A_BIST_DIN  <= {P_DATA_WIDTH{op_ones}};
                A_BIST_BM   <= '1;
            end else begin
                A_BIST_EN   <= 1'b0;
                A_BIST_MEN  <= 1'b0;
                A_BIST_WEN  <= 1'b0;
                A_BIST_REN  <= 1'b0;
                A_BIST_ADDR <= '0;
                A_BIST_DIN  <= '0;
                A_BIST_BM   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rm_ihpsg13_1p_256x48_bist_ctrl.sv
// Directed bench for the March C- BIST controller with a behavioural 256x48 SRAM.
module tb_rm_ihpsg13_1p_256x48_bist_ctrl;

    localparam int DW = 48;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          A_RST, A_START;
    logic          A_BUSY, A_DONE, A_FAIL;
    logic [AW-1:0] A_FAIL_ADDR;
    logic [2:0]    A_FAIL_ELEM;
    logic [DW-1:0] A_FAIL_BITS;
    logic          A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN;
    logic [AW-1:0] A_BIST_ADDR;
    logic [DW-1:0] A_BIST_DIN, A_BIST_BM;
    logic [DW-1:0] A_DOUT = '0;

    always #5 clk = ~clk;

    rm_ihpsg13_1p_256x48_bist_ctrl #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) dut (
        .A_CLK(clk), .A_RST(A_RST), .A_START(A_START),
        .A_BUSY(A_BUSY), .A_DONE(A_DONE), .A_FAIL(A_FAIL),
        .A_FAIL_ADDR(A_FAIL_ADDR), .A_FAIL_ELEM(A_FAIL_ELEM), .A_FAIL_BITS(A_FAIL_BITS),
        .A_BIST_EN(A_BIST_EN), .A_BIST_MEN(A_BIST_MEN), .A_BIST_WEN(A_BIST_WEN),
        .A_BIST_REN(A_BIST_REN), .A_BIST_ADDR(A_BIST_ADDR), .A_BIST_DIN(A_BIST_DIN),
        .A_BIST_BM(A_BIST_BM), .A_DOUT(A_DOUT)
    );

    // Behavioural SRAM with an optional stuck-at-1 on bit 5 when reading 0x10.
    logic [DW-1:0] mem [0:255];
    logic          fault_en = 1'b0;
    always @(posedge clk) begin
        if (A_BIST_EN && A_BIST_MEN) begin
            if (A_BIST_WEN)
                mem[A_BIST_ADDR] <= (mem[A_BIST_ADDR] & ~A_BIST_BM) | (A_BIST_DIN & A_BIST_BM);
            if (A_BIST_REN)
                A_DOUT <= mem[A_BIST_ADDR] |
                          ((fault_en && A_BIST_ADDR == 8'h10) ? 48'h0000_0000_0020 : 48'h0);
        end
    end

    int errors = 0;
    int checks = 0;
    int n_wr, n_rd, n_viol;

    typedef struct {
        int         op;
        logic [7:0] addr;
        logic       wen;
        logic       ren;
        logic       din_ones;
    } vec_t;
    vec_t tbl [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_ctl"}, {A_BUSY, A_DONE, A_FAIL, A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN}, '0);
        check({name, "_fail_info"}, {A_FAIL_ADDR, A_FAIL_ELEM, A_FAIL_BITS}, '0);
        check({name, "_port"}, {A_BIST_ADDR, A_BIST_DIN, A_BIST_BM}, '0);
    endtask

    // Launch a run and watch the port each cycle; j is the number of edges since the start edge.
    task automatic run_watch(input int rst_at, input int re1, input int re2, input bit use_tbl,
                             output int done_at, output logic done0, output logic fail0,
                             output logic busy0);
        n_wr = 0; n_rd = 0; n_viol = 0;
        done_at = -1; done0 = 1'bx; fail0 = 1'bx; busy0 = 1'bx;
        @(negedge clk);
        A_START = 1'b1;
        @(posedge clk);
        for (int j = 0; j <= 3000; j++) begin
            @(negedge clk);
            A_START = 1'b0;
            if (j == 0) begin
                done0 = A_DONE; fail0 = A_FAIL; busy0 = A_BUSY;
            end
            if (A_DONE) begin
                done_at = j;
                break;
            end
            if (!A_BUSY) n_viol++;
            if (A_BIST_EN) begin
                if (A_BIST_WEN) n_wr++;
                if (A_BIST_REN) n_rd++;
                if (!A_BIST_MEN || A_BIST_BM != '1 || (A_BIST_WEN == A_BIST_REN) ||
                    (A_BIST_REN && A_BIST_DIN != '0) || j >= 2560)
                    n_viol++;
            end else if (A_BIST_MEN || A_BIST_WEN || A_BIST_REN || (|A_BIST_ADDR) ||
                         (|A_BIST_DIN) || (|A_BIST_BM) || j < 2560) begin
                n_viol++;
            end
            if (use_tbl) begin
                foreach (tbl[k]) begin
                    if (tbl[k].op == j) begin
                        check($sformatf("op%0d_addr", j), A_BIST_ADDR, tbl[k].addr);
                        check($sformatf("op%0d_wen_ren", j), {A_BIST_WEN, A_BIST_REN},
                              {tbl[k].wen, tbl[k].ren});
                        check($sformatf("op%0d_din", j), A_BIST_DIN, {DW{tbl[k].din_ones}});
                    end
                end
            end
            if (j == re1 || j == re2) A_START = 1'b1;
            if (j == rst_at) begin
                A_RST = 1'b1;
                @(posedge clk);
                @(negedge clk);
                A_RST = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   done_at;
        logic d0, f0, b0;
        int   en_seen;

        tbl[0]  = '{0,    8'h00, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{255,  8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{256,  8'h00, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{257,  8'h00, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{767,  8'hFF, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{768,  8'h00, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1279, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1280, 8'hFF, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1791, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1792, 8'hFF, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{2303, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{2304, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{2559, 8'hFF, 1'b0, 1'b1, 1'b0};

        A_RST = 1'b1;
        A_START = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        A_RST = 1'b0;

        // Fault-free run with op-index table checks.
        run_watch(-1, -1, -1, 1'b1, done_at, d0, f0, b0);
        check("run1_busy_first", b0, 1'b1);
        check("run1_done_at", done_at, 2561);
        check("run1_fail", A_FAIL, 1'b0);
        check("run1_busy_at_done", A_BUSY, 1'b0);
        check("run1_writes", n_wr, 1280);
        check("run1_reads", n_rd, 1280);
        check("run1_port_violations", n_viol, 0);
        repeat (3) @(negedge clk);
        check("run1_done_held", {A_DONE, A_BUSY, A_BIST_EN}, 3'b100);

        // Stuck-at-1 on bit 5 at address 0x10.
        fault_en = 1'b1;
        run_watch(-1, -1, -1, 1'b0, done_at, d0, f0, b0);
        check("run2_done_at", done_at, 2561);
        check("run2_fail", A_FAIL, 1'b1);
        check("run2_fail_addr", A_FAIL_ADDR, 8'h10);
        check("run2_fail_elem", A_FAIL_ELEM, 3'd1);
        check("run2_fail_bits", A_FAIL_BITS, 48'h0000_0000_0020);

        // Restart after a failing run, with ignored re-pulses during RUN and FLUSH.
        fault_en = 1'b0;
        run_watch(-1, 5, 2560, 1'b0, done_at, d0, f0, b0);
        check("run3_start_clears_done", d0, 1'b0);
        check("run3_start_clears_fail", f0, 1'b0);
        check("run3_busy_first", b0, 1'b1);
        check("run3_done_at", done_at, 2561);
        check("run3_fail", A_FAIL, 1'b0);
        check("run3_port_violations", n_viol, 0);

        // Reset mid-run after a failure has already been captured.
        fault_en = 1'b1;
        run_watch(1000, -1, -1, 1'b0, done_at, d0, f0, b0);
        check("run4_no_done", done_at, -1);
        check_idle_outputs("run4_after_reset");
        en_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (A_BIST_EN || A_DONE || A_BUSY) en_seen++;
        end
        check("run4_stays_idle", en_seen, 0);

        // Complete run after the abort.
        fault_en = 1'b0;
        run_watch(-1, -1, -1, 1'b0, done_at, d0, f0, b0);
        check("run5_done_at", done_at, 2561);
        check("run5_fail", A_FAIL, 1'b0);
        check("run5_ops", n_wr + n_rd, 2560);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
